// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter types and frame constants.
// Optional parity bit is enabled with macro UART_TX_PARITY_EN.
package uart_tx_pkg;

  localparam int         DATA_BITS = 8;
  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       LINE_IDLE = 1'b1;
  localparam logic       START_BIT = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_baud_cntr.sv
// 16-bit bit-period down counter for the UART transmitter.
// Ports: CLOCK, reset (sync, high), en (frame active), load, expire (last cycle of a bit).
module uart_tx_baud_cntr #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic en,
  input  logic load,
  output logic expire
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 16'd1;
    end
  end

  // A bit spans the counts RELOAD..0, i.e. exactly CLKS_PER_BIT cycles.
  assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: one-byte holding buffer, 8N1 framing, sticky overflow.
// Ports: CLOCK, reset, Wr_en, tx_data_in, clr_ovrflw -> Tx_out, tx_empty, busy, tx_done, overflow.
// Macro UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_top
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       Wr_en,
  input  logic [7:0] tx_data_in,
  input  logic       clr_ovrflw,
  output logic       Tx_out,
  output logic       tx_empty,
  output logic       busy,
  output logic       tx_done,
  output logic       overflow
);

  tx_state_e  state, state_nxt;
  logic [2:0] bit_idx, bit_idx_nxt, idx_inc;
  logic [7:0] shreg, buf_data;
  logic       buf_full;
  logic       tx_reg, tx_nxt;
  logic       take_buf, bit_end;
  logic       wr_ok, wr_drop;

  uart_tx_baud_cntr #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLOCK (CLOCK),
    .reset (reset),
    .en    (busy),
    .load  (take_buf | bit_end),
    .expire(bit_end)
  );

  assign idx_inc = bit_idx + 3'd1;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      tx_reg  <= LINE_IDLE;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      tx_reg  <= tx_nxt;
      if (take_buf) shreg <= buf_data;
    end
  end

  // tx_nxt is the line level of the state being entered, so the
  // serial output stays a plain register with no decode glitches.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    tx_nxt      = tx_reg;
    take_buf    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (buf_full) begin
          state_nxt = ST_START;
          take_buf  = 1'b1;
          tx_nxt    = START_BIT;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
            tx_nxt    = ^shreg;
`else
            state_nxt = ST_STOP;
            tx_nxt    = LINE_IDLE;
`endif
          end else begin
            bit_idx_nxt = idx_inc;
            tx_nxt      = shreg[idx_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt = ST_STOP;
          tx_nxt    = LINE_IDLE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (buf_full) begin
            state_nxt = ST_START;
            take_buf  = 1'b1;
            tx_nxt    = START_BIT;
          end else begin
            state_nxt = ST_IDLE;
            tx_nxt    = LINE_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = LINE_IDLE;
      end
    endcase
  end

  // A write landing on the transfer edge refills the slot being vacated.
  assign wr_ok   = Wr_en && (!buf_full || take_buf);
  assign wr_drop = Wr_en && buf_full && !take_buf;

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        buf_data <= tx_data_in;
        buf_full <= 1'b1;
      end else if (take_buf) begin
        buf_full <= 1'b0;
      end
      if (wr_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovrflw) begin
        overflow <= 1'b0;
      end
    end
  end

  assign Tx_out   = tx_reg;
  assign tx_empty = ~buf_full;
  assign busy     = (state != ST_IDLE);
  assign tx_done  = (state == ST_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top against a line-level queue model.
// Directed frames plus random writes, clears and resets; CLKS_PER_BIT=4.
module tb_uart_tx_top;

  localparam int CLKS = 4;

  logic       CLOCK = 1'b0;
  logic       reset = 1'b1;
  logic       Wr_en = 1'b0;
  logic [7:0] tx_data_in = '0;
  logic       clr_ovrflw = 1'b0;
  logic       Tx_out, tx_empty, busy, tx_done, overflow;

  uart_tx_top #(
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .CLOCK     (CLOCK),
    .reset     (reset),
    .Wr_en     (Wr_en),
    .tx_data_in(tx_data_in),
    .clr_ovrflw(clr_ovrflw),
    .Tx_out    (Tx_out),
    .tx_empty  (tx_empty),
    .busy      (busy),
    .tx_done   (tx_done),
    .overflow  (overflow)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  // Model: the wire as a queue of per-cycle line levels for the rest
  // of the current frame, plus a one-byte holding slot.
  bit       m_q[$];
  bit [7:0] m_buf;
  bit       m_full  = 1'b0;
  bit       m_ovf   = 1'b0;
  bit       m_frame = 1'b0;
  bit       exp_tx  = 1'b1;

  task automatic push_bit(input bit v);
    for (int k = 0; k < CLKS; k++) m_q.push_back(v);
  endtask

  task automatic build_frame(input bit [7:0] d);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(d[i]);
`ifdef UART_TX_PARITY_EN
    push_bit(^d);
`endif
    push_bit(1'b1);
  endtask

  always @(posedge CLOCK) begin : model
    bit xfer;
    bit drop;
    cyc++;
    xfer = 1'b0;
    drop = 1'b0;
    if (reset) begin
      m_q.delete();
      m_full  = 1'b0;
      m_ovf   = 1'b0;
      m_frame = 1'b0;
      exp_tx  = 1'b1;
    end else begin
      if (m_q.size() > 0) begin
        exp_tx  = m_q.pop_front();
        m_frame = 1'b1;
      end else if (m_full) begin
        build_frame(m_buf);
        exp_tx  = m_q.pop_front();
        m_frame = 1'b1;
        xfer    = 1'b1;
      end else begin
        exp_tx  = 1'b1;
        m_frame = 1'b0;
      end
      if (xfer) m_full = 1'b0;
      if (Wr_en) begin
        if (!m_full) begin
          m_buf  = tx_data_in;
          m_full = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovrflw) m_ovf = 1'b0;
    end
  end

  always @(negedge CLOCK) begin
    if (chk_en) begin
      check_eq("tx_out", Tx_out, exp_tx);
      check_eq("tx_empty", tx_empty, !m_full);
      check_eq("busy", busy, m_frame);
      check_eq("tx_done", tx_done, m_frame && (m_q.size() == 0));
      check_eq("overflow", overflow, m_ovf);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    Wr_en      = 1'b1;
    tx_data_in = d;
    step(1);
    Wr_en      = 1'b0;
  endtask

  initial begin
    int  wr_cyc;
    int  lat;
    bit  seen;
    step(1);
    chk_en = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);

    wr_cyc = cyc;
    seen   = 1'b0;
    lat    = 0;
    wr(8'hA5);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLOCK);
      if (tx_done && !seen) begin
        seen = 1'b1;
        lat  = cyc - wr_cyc;
      end
    end
    check_eq("done_seen", seen, 1'b1);
`ifdef UART_TX_PARITY_EN
    check_eq("done_lat", lat, 45);
`else
    check_eq("done_lat", lat, 41);
`endif
    step(3);

    wr(8'h55);
    step(10);
    wr(8'h0F);
    step(100);

    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    step(5);
    clr_ovrflw = 1'b1;
    wr(8'h04);
    clr_ovrflw = 1'b1;
    step(1);
    clr_ovrflw = 1'b0;
    step(100);

    wr(8'h96);
    wr(8'h11);
    step(24);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    wr(8'h3C);
    step(60);

    wr(8'h07);
    step(50);
    wr(8'h03);
    step(50);

    for (int i = 0; i < 600; i++) begin
      Wr_en      = ($urandom_range(0, 15) == 0);
      tx_data_in = 8'($urandom);
      clr_ovrflw = ($urandom_range(0, 24) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      step(1);
    end
    Wr_en      = 1'b0;
    clr_ovrflw = 1'b0;
    reset      = 1'b0;
    step(120);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
